// File: rtl/gbfflgofm_pkg.sv
// Shared constants for the flag output-feature-map global buffer (RAM wrapper, writer, reader).
package gbfflgofm_pkg;

    localparam int unsigned SRAM_DEPTH_BIT = 6;
    localparam int unsigned SRAM_WIDTH     = 28;
    localparam int unsigned SKID_DEPTH     = 2;

    typedef logic [1:0] skid_occ_t;

    // True when one more word may be requested from the RAM without overrunning the skid buffer:
    // words held + word returning this cycle - word leaving this cycle must stay below capacity.
    function automatic logic slot_free(input skid_occ_t occ, input logic inflight,
                                       input logic pop);
        logic [2:0] held;
        logic [2:0] limit;
        held  = {1'b0, occ} + {2'b00, inflight};
        limit = 3'(SKID_DEPTH) + {2'b00, pop};
        return held < limit;
    endfunction

endpackage

// File: rtl/gbfflgofm_skid.sv
// Two-entry valid/ready FIFO that absorbs the one-cycle RAM read latency; sync clear flushes it.
module gbfflgofm_skid
    import gbfflgofm_pkg::*;
#(
    parameter int unsigned Width = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             in_valid_i,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    output logic [Width-1:0] out_data_o,
    input  logic             out_ready_i,
    output skid_occ_t        occ_o
);

    logic [Width-1:0] mem_q [2];
    logic [Width-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    skid_occ_t        occ_q, occ_d;
    logic             push;
    logic             pop;

    assign pop  = out_ready_i && (occ_q != 2'd0);
    // When full, a push only lands if the head is leaving in the same cycle.
    assign push = in_valid_i && ((occ_q != 2'd2) || pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (clear_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            occ_d    = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = in_data_i;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            occ_d = occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign out_valid_o = (occ_q != 2'd0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign occ_o       = occ_q;

endmodule

// File: rtl/gbfflgofm_rd_ctrl.sv
// Read-side controller for the flag OFM global buffer: steals idle address cycles from the
// producer, tracks unread words and streams them out in write order through a skid buffer.
module gbfflgofm_rd_ctrl #(
    parameter int unsigned SRAM_DEPTH_BIT = gbfflgofm_pkg::SRAM_DEPTH_BIT,
    parameter int unsigned SRAM_DEPTH     = 2 ** SRAM_DEPTH_BIT,
    parameter int unsigned SRAM_WIDTH     = gbfflgofm_pkg::SRAM_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    ram_write_en,
    output logic                    ram_read_en,
    output logic [SRAM_DEPTH_BIT-1:0] ram_addr_r,
    input  logic [SRAM_WIDTH-1:0]   ram_data_out,
    output logic [SRAM_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SRAM_DEPTH_BIT:0] unread,
    output logic                    empty,
    output logic                    overflow
);

    import gbfflgofm_pkg::*;

    localparam int unsigned CntW = SRAM_DEPTH_BIT + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(SRAM_DEPTH);

    logic [SRAM_DEPTH_BIT-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]           unread_q, unread_d;
    logic                      inflight_q, inflight_d;
    logic                      overflow_q, overflow_d;
    skid_occ_t                 skid_occ;
    logic                      pop;
    logic                      issue;

    assign pop = out_valid && out_ready;

    // A producer write owns the shared RAM address, so reads only use write-free cycles.
    assign issue = (unread_q != '0) && !ram_write_en && !clear
                   && slot_free(skid_occ, inflight_q, pop);

    assign ram_read_en = issue;
    assign ram_addr_r  = rd_ptr_q;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        unread_d   = unread_q;
        inflight_d = issue;
        overflow_d = overflow_q;
        if (clear) begin
            rd_ptr_d   = '0;
            unread_d   = '0;
            inflight_d = 1'b0;
            overflow_d = 1'b0;
        end else if (ram_write_en) begin
            // A write into a full buffer overwrites an unread word; the count saturates.
            if (unread_q == DepthCnt) begin
                overflow_d = 1'b1;
            end else begin
                unread_d = unread_q + CntW'(1);
            end
        end else if (issue) begin
            unread_d = unread_q - CntW'(1);
            rd_ptr_d = rd_ptr_q + SRAM_DEPTH_BIT'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            unread_q   <= '0;
            inflight_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            unread_q   <= unread_d;
            inflight_q <= inflight_d;
            overflow_q <= overflow_d;
        end
    end

    // Data returning for a read issued before a clear is dropped here.
    gbfflgofm_skid #(
        .Width(SRAM_WIDTH)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (clear),
        .in_valid_i (inflight_q && !clear),
        .in_data_i  (ram_data_out),
        .out_valid_o(out_valid),
        .out_data_o (out_data),
        .out_ready_i(out_ready),
        .occ_o      (skid_occ)
    );

    assign unread   = unread_q;
    assign overflow = overflow_q;
    assign empty    = (unread_q == '0) && !inflight_q && (skid_occ == 2'd0);

endmodule

// File: tb/tb_gbfflgofm_rd_ctrl.sv
// Scoreboard bench for gbfflgofm_rd_ctrl: bench-side RAM model, directed write/drain scenarios.
module tb_gbfflgofm_rd_ctrl;

    localparam int unsigned DB = 6;
    localparam int unsigned W  = 28;
    localparam int unsigned D  = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          ram_write_en = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  wdata = '0;
    logic          ram_read_en;
    logic [DB-1:0] ram_addr_r;
    logic [W-1:0]  ram_data_out;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic [DB:0]   unread;
    logic          empty;
    logic          overflow;

    logic [W-1:0]  mem [D];
    logic [DB-1:0] waddr;
    logic [W-1:0]  exp_q [$];

    int cyc = 0;
    int s_total = 0, s_pass = 0;
    int m_total = 0, m_pass = 0;
    int rd_cnt = 0, pop_cnt = 0, wrap_cnt = 0;
    int valid_rise_cyc = 0, last_pop_cyc = 0;

    gbfflgofm_rd_ctrl #(
        .SRAM_DEPTH_BIT(DB),
        .SRAM_DEPTH    (D),
        .SRAM_WIDTH    (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .ram_write_en(ram_write_en),
        .ram_read_en (ram_read_en),
        .ram_addr_r  (ram_addr_r),
        .ram_data_out(ram_data_out),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .unread      (unread),
        .empty       (empty),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port RAM: sequential write address, registered read data.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr        <= '0;
            ram_data_out <= '0;
        end else begin
            if (clear) begin
                waddr <= '0;
            end else if (ram_write_en) begin
                mem[waddr] <= wdata;
                waddr      <= waddr + DB'(1);
            end
            if (ram_read_en) begin
                ram_data_out <= mem[ram_addr_r];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        s_total++;
        if (act === exp) s_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic mchk(input string name, input logic [31:0] act, input logic [31:0] exp);
        m_total++;
        if (act === exp) m_pass++;
        else $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    endtask

    // Monitor: scoreboard pops, address sequence and write/read exclusivity, mid-cycle sampling.
    initial begin
        logic [DB-1:0] exp_raddr;
        logic [DB-1:0] prev_raddr;
        logic          prev_valid;
        logic [W-1:0]  e;
        exp_raddr  = '0;
        prev_raddr = '0;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_raddr  = '0;
                prev_raddr = '0;
                prev_valid = 1'b0;
            end else begin
                if (ram_write_en) mchk("no_read_on_write", 32'(ram_read_en), 32'd0);
                if (ram_read_en) begin
                    mchk("read_addr", 32'(ram_addr_r), 32'(exp_raddr));
                    if (prev_raddr == DB'(D - 1) && ram_addr_r == '0) wrap_cnt++;
                    prev_raddr = ram_addr_r;
                    exp_raddr  = exp_raddr + DB'(1);
                    rd_cnt++;
                end
                if (out_valid && !prev_valid) valid_rise_cyc = cyc;
                prev_valid = out_valid;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        m_total++;
                        $display("FAIL unexpected_word @cyc %0d: got 0x%0h, want none", cyc,
                                 out_data);
                    end else begin
                        e = exp_q.pop_front();
                        mchk("stream_data", 32'(out_data), 32'(e));
                    end
                    pop_cnt++;
                    last_pop_cyc = cyc;
                end
                if (clear) exp_raddr = '0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [W-1:0] v);
        step();
        clear        = 1'b0;
        ram_write_en = 1'b1;
        wdata        = v;
        exp_q.push_back(v);
    endtask

    task automatic nowr();
        step();
        clear        = 1'b0;
        ram_write_en = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            nowr();
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_read_en"},  32'(ram_read_en), 32'd0);
        check({tag, "_addr_r"},   32'(ram_addr_r),  32'd0);
        check({tag, "_valid"},    32'(out_valid),   32'd0);
        check({tag, "_data"},     32'(out_data),    32'd0);
        check({tag, "_unread"},   32'(unread),      32'd0);
        check({tag, "_empty"},    32'(empty),       32'd1);
        check({tag, "_overflow"}, 32'(overflow),    32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int last_wr;
        int rd0;
        int rdy_cyc;
        int wrap0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();

        // Back-to-back writes block reads; first read takes the cycle after the last write.
        for (int i = 1; i <= 5; i++) wr(W'(i));
        last_wr = cyc;
        nowr();
        #1;
        check("issue_after_writes", 32'(ram_read_en), 32'd1);
        check("unread_after_5", 32'(unread), 32'd5);
        drain(40);
        check("first_valid_latency", 32'(valid_rise_cyc - last_wr), 32'd3);
        nowr();
        check("empty_after_drain", 32'(empty), 32'd1);

        // Fill to depth, then one more write sets overflow; clear recovers.
        for (int i = 0; i < 64; i++) wr(W'(32'h100 + i));
        wr(W'(32'h1ff));
        check("unread_full", 32'(unread), 32'd64);
        check("overflow_not_yet", 32'(overflow), 32'd0);
        step();
        ram_write_en = 1'b0;
        clear = 1'b1;
        exp_q.delete();
        #1;
        check("unread_saturated", 32'(unread), 32'd64);
        check("overflow_set", 32'(overflow), 32'd1);
        check("no_issue_during_clear", 32'(ram_read_en), 32'd0);
        nowr();
        check("overflow_cleared", 32'(overflow), 32'd0);
        check("unread_cleared", 32'(unread), 32'd0);
        check("valid_after_clear", 32'(out_valid), 32'd0);
        check("empty_after_clear", 32'(empty), 32'd1);

        // Backpressure: only two reads fit in the skid buffer.
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) wr(W'(32'h300 + i));
        rd0 = rd_cnt;
        repeat (6) nowr();
        #1;
        check("bp_read_count", 32'(rd_cnt - rd0), 32'd2);
        check("bp_unread", 32'(unread), 32'd8);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_head", 32'(out_data), 32'h300);
        check("bp_no_issue", 32'(ram_read_en), 32'd0);
        repeat (3) nowr();
        check("bp_head_stable", 32'(out_data), 32'h300);
        step();
        out_ready = 1'b1;
        rdy_cyc = cyc;
        drain(40);
        check("bp_no_gaps", 32'(last_pop_cyc - rdy_cyc), 32'd9);

        // Alternating writes after a preload.
        for (int i = 0; i < 4; i++) wr(W'(32'h400 + i));
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) wr(W'(32'h410 + i));
            else nowr();
        end
        drain(40);

        // Bursty traffic across the address wrap.
        wrap0 = wrap_cnt;
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < 7; k++) wr(W'(32'h2000 + b * 7 + k));
            repeat (3) nowr();
        end
        drain(120);
        check("addr_wrap_seen", 32'(wrap_cnt > wrap0), 32'd1);

        // Clear one cycle after issue: the returning word must be dropped.
        wr(W'(32'h5a5));
        nowr();
        #1;
        check("issue_before_clear", 32'(ram_read_en), 32'd1);
        step();
        ram_write_en = 1'b0;
        clear = 1'b1;
        exp_q.delete();
        nowr();
        check("clear_drop_valid", 32'(out_valid), 32'd0);
        check("clear_drop_empty", 32'(empty), 32'd1);
        repeat (3) nowr();
        check("clear_drop_still_idle", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) wr(W'(32'h600 + i));
        repeat (4) nowr();
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_vals("async_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) wr(W'(32'h700 + i));
        drain(40);
        nowr();
        check("empty_after_reset_traffic", 32'(empty), 32'd1);

        repeat (2) nowr();
        $display("%0d/%0d checks passed", s_pass + m_pass, s_total + m_total);
        $finish;
    end

endmodule
